// File: rtl/snake_pkg.sv
// Shared constants, FSM encodings and reward payload type for the snake game blocks.
package snake_pkg;

  localparam int unsigned COORD_W = 6;
  localparam int unsigned KIND_W  = 2;
  localparam int unsigned SCORE_W = 3;
  localparam int unsigned STATE_W = 3;

  // Reward slot FSM state encodings
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE   = 3'd1;
  localparam logic [STATE_W-1:0] ST_QUERY    = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_OCC = 3'd3;
  localparam logic [STATE_W-1:0] ST_ACTIVE   = 3'd4;
  localparam logic [STATE_W-1:0] ST_FINISH   = 3'd5;

  // Legal playfield bounds (inclusive)
  localparam int unsigned X_MIN = 4;
  localparam int unsigned X_MAX = 19;
  localparam int unsigned Y_MIN = 2;
  localparam int unsigned Y_MAX = 9;

  // Reward class codes
  localparam logic [KIND_W-1:0] REWARD_NONE = 2'd0;
  localparam logic [KIND_W-1:0] REWARD_T1   = 2'd1;
  localparam logic [KIND_W-1:0] REWARD_T2   = 2'd2;
  localparam logic [KIND_W-1:0] REWARD_T3   = 2'd3;

  // Score awarded per reward class
  localparam logic [SCORE_W-1:0] SCORE_T1 = 3'd1;
  localparam logic [SCORE_W-1:0] SCORE_T2 = 3'd3;
  localparam logic [SCORE_W-1:0] SCORE_T3 = 3'd5;

  // A placed or candidate reward on the grid
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [KIND_W-1:0]  kind;
  } reward_t;

  // Score value for a reward class; unknown/none scores nothing
  function automatic logic [SCORE_W-1:0] score_of(input logic [KIND_W-1:0] kind);
    case (kind)
      REWARD_T1: score_of = SCORE_T1;
      REWARD_T2: score_of = SCORE_T2;
      REWARD_T3: score_of = SCORE_T3;
      default:   score_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/grid_nudge.sv
// Combinational grid helper: saturates (x, y) into the legal window and optionally
// steps one cell to the right, wrapping to the next row and back to the top row.
module grid_nudge
  import snake_pkg::*;
#(
  parameter int unsigned X_LO = snake_pkg::X_MIN,
  parameter int unsigned X_HI = snake_pkg::X_MAX,
  parameter int unsigned Y_LO = snake_pkg::Y_MIN,
  parameter int unsigned Y_HI = snake_pkg::Y_MAX
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_step,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y
);

  logic [COORD_W-1:0] w_cx;
  logic [COORD_W-1:0] w_cy;

  // Clamp into bounds, then apply the optional raster step with wrap
  always_comb begin
    w_cx = i_x;
    w_cy = i_y;
    if (i_x < COORD_W'(X_LO))      w_cx = COORD_W'(X_LO);
    else if (i_x > COORD_W'(X_HI)) w_cx = COORD_W'(X_HI);
    if (i_y < COORD_W'(Y_LO))      w_cy = COORD_W'(Y_LO);
    else if (i_y > COORD_W'(Y_HI)) w_cy = COORD_W'(Y_HI);

    o_x = w_cx;
    o_y = w_cy;
    if (i_step) begin
      if (w_cx >= COORD_W'(X_HI)) begin
        o_x = COORD_W'(X_LO);
        if (w_cy >= COORD_W'(Y_HI)) o_y = COORD_W'(Y_LO);
        else                        o_y = w_cy + COORD_W'(1);
      end else begin
        o_x = w_cx + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/reward_slot_manager.sv
// Reward slot manager: answers the generator's set_require/set_finish handshake,
// finds a free cell via occupancy queries, holds the reward, and scores eats.
// Optional blink of reward_visible while placed: define REWARD_BLINK_EN.
module reward_slot_manager
  import snake_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_RETRY     = 8,
  parameter int unsigned X_MIN         = snake_pkg::X_MIN,
  parameter int unsigned X_MAX         = snake_pkg::X_MAX,
  parameter int unsigned Y_MIN         = snake_pkg::Y_MIN,
  parameter int unsigned Y_MAX         = snake_pkg::Y_MAX
`ifdef REWARD_BLINK_EN
  , parameter int unsigned BLINK_PERIOD = 8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_require,
  input  logic [KIND_W-1:0]  reward_type,
  input  logic [COORD_W-1:0] random_xpos,
  input  logic [COORD_W-1:0] random_ypos,
  output logic               set_finish,
  output logic               occ_req,
  output logic [COORD_W-1:0] occ_xpos,
  output logic [COORD_W-1:0] occ_ypos,
  input  logic               occ_valid,
  input  logic               occ_hit,
  input  logic               head_valid,
  input  logic [COORD_W-1:0] head_xpos,
  input  logic [COORD_W-1:0] head_ypos,
  output logic               reward_active,
  output logic               reward_visible,
  output logic [COORD_W-1:0] reward_xpos,
  output logic [COORD_W-1:0] reward_ypos,
  output logic [KIND_W-1:0]  reward_kind,
  output logic               eat_pulse,
  output logic [SCORE_W-1:0] score_add,
  output logic               expire_pulse,
  output logic               reject_pulse
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned RETRY_W  = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
`ifdef REWARD_BLINK_EN
  localparam int unsigned BLINK_W  = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
`endif

  logic [STATE_W-1:0]  r_state,      w_state_nxt;
  logic [SETTLE_W-1:0] r_settle_cnt, w_settle_nxt;
  logic [RETRY_W-1:0]  r_retry,      w_retry_nxt;
  reward_t             r_cand,       w_cand_nxt;
  reward_t             r_reward,     w_reward_nxt;
  logic                r_occ_req,    w_occ_req_nxt;
  logic                r_set_finish, w_finish_nxt;
  logic                r_active,     w_active_nxt;
  logic                r_visible,    w_visible_nxt;
  logic                r_eat,        w_eat_nxt;
  logic [SCORE_W-1:0]  r_score,      w_score_nxt;
  logic                r_expire,     w_expire_nxt;
  logic                r_reject,     w_reject_nxt;
`ifdef REWARD_BLINK_EN
  logic [BLINK_W-1:0]  r_blink_cnt,  w_blink_nxt;
`endif

  logic [COORD_W-1:0]  w_ng_in_x, w_ng_in_y;
  logic                w_ng_step;
  logic [COORD_W-1:0]  w_ng_x, w_ng_y;
  logic                w_head_hit;

  // Nudge unit clamps raw generator coordinates while settling, else steps the candidate
  assign w_ng_in_x = (r_state == ST_SETTLE) ? random_xpos : r_cand.x;
  assign w_ng_in_y = (r_state == ST_SETTLE) ? random_ypos : r_cand.y;
  assign w_ng_step = (r_state != ST_SETTLE);

  grid_nudge #(
    .X_LO (X_MIN),
    .X_HI (X_MAX),
    .Y_LO (Y_MIN),
    .Y_HI (Y_MAX)
  ) u_grid_nudge (
    .i_x    (w_ng_in_x),
    .i_y    (w_ng_in_y),
    .i_step (w_ng_step),
    .o_x    (w_ng_x),
    .o_y    (w_ng_y)
  );

  assign w_head_hit = head_valid && (head_xpos == r_reward.x) && (head_ypos == r_reward.y);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_settle_nxt  = r_settle_cnt;
    w_retry_nxt   = r_retry;
    w_cand_nxt    = r_cand;
    w_reward_nxt  = r_reward;
    w_occ_req_nxt = 1'b0;
    w_finish_nxt  = r_set_finish;
    w_active_nxt  = r_active;
    w_eat_nxt     = 1'b0;
    w_score_nxt   = '0;
    w_expire_nxt  = 1'b0;
    w_reject_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (set_require && (reward_type != REWARD_NONE)) begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = '0;
        end
      end

      ST_SETTLE: begin
        if (!set_require) begin
          w_state_nxt = ST_IDLE;
        end else if (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          w_cand_nxt.x    = w_ng_x;
          w_cand_nxt.y    = w_ng_y;
          w_cand_nxt.kind = reward_type;
          w_retry_nxt     = '0;
          w_occ_req_nxt   = 1'b1;
          w_state_nxt     = ST_QUERY;
        end else begin
          w_settle_nxt = r_settle_cnt + SETTLE_W'(1);
        end
      end

      ST_QUERY: begin
        w_state_nxt = set_require ? ST_WAIT_OCC : ST_IDLE;
      end

      ST_WAIT_OCC: begin
        if (!set_require) begin
          w_state_nxt = ST_IDLE;
        end else if (occ_valid) begin
          if (!occ_hit) begin
            w_reward_nxt = r_cand;
            w_active_nxt = 1'b1;
            w_state_nxt  = ST_ACTIVE;
          end else if (r_retry == RETRY_W'(MAX_RETRY - 1)) begin
            w_reject_nxt = 1'b1;
            w_finish_nxt = 1'b1;
            w_state_nxt  = ST_FINISH;
          end else begin
            w_cand_nxt.x  = w_ng_x;
            w_cand_nxt.y  = w_ng_y;
            w_retry_nxt   = r_retry + RETRY_W'(1);
            w_occ_req_nxt = 1'b1;
            w_state_nxt   = ST_QUERY;
          end
        end
      end

      ST_ACTIVE: begin
        // An eat in the same cycle as withdrawal still scores
        if (w_head_hit) begin
          w_eat_nxt    = 1'b1;
          w_score_nxt  = score_of(r_reward.kind);
          w_active_nxt = 1'b0;
          w_finish_nxt = 1'b1;
          w_state_nxt  = ST_FINISH;
        end else if (!set_require) begin
          w_expire_nxt = 1'b1;
          w_active_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end

      ST_FINISH: begin
        if (!set_require) begin
          w_finish_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_finish_nxt = 1'b0;
        w_active_nxt = 1'b0;
      end
    endcase

`ifdef REWARD_BLINK_EN
    // Blink starts lit on placement and toggles every BLINK_PERIOD cycles while placed
    w_blink_nxt   = '0;
    w_visible_nxt = 1'b0;
    if (w_state_nxt == ST_ACTIVE) begin
      if (r_state != ST_ACTIVE) begin
        w_visible_nxt = 1'b1;
      end else if (r_blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
        w_visible_nxt = !r_visible;
      end else begin
        w_blink_nxt   = r_blink_cnt + BLINK_W'(1);
        w_visible_nxt = r_visible;
      end
    end
`else
    w_visible_nxt = w_active_nxt;
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_retry      <= '0;
      r_cand       <= '0;
      r_reward     <= '0;
      r_occ_req    <= 1'b0;
      r_set_finish <= 1'b0;
      r_active     <= 1'b0;
      r_visible    <= 1'b0;
      r_eat        <= 1'b0;
      r_score      <= '0;
      r_expire     <= 1'b0;
      r_reject     <= 1'b0;
`ifdef REWARD_BLINK_EN
      r_blink_cnt  <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_retry      <= w_retry_nxt;
      r_cand       <= w_cand_nxt;
      r_reward     <= w_reward_nxt;
      r_occ_req    <= w_occ_req_nxt;
      r_set_finish <= w_finish_nxt;
      r_active     <= w_active_nxt;
      r_visible    <= w_visible_nxt;
      r_eat        <= w_eat_nxt;
      r_score      <= w_score_nxt;
      r_expire     <= w_expire_nxt;
      r_reject     <= w_reject_nxt;
`ifdef REWARD_BLINK_EN
      r_blink_cnt  <= w_blink_nxt;
`endif
    end
  end

  assign set_finish     = r_set_finish;
  assign occ_req        = r_occ_req;
  assign occ_xpos       = r_cand.x;
  assign occ_ypos       = r_cand.y;
  assign reward_active  = r_active;
  assign reward_visible = r_visible;
  assign reward_xpos    = r_reward.x;
  assign reward_ypos    = r_reward.y;
  assign reward_kind    = r_reward.kind;
  assign eat_pulse      = r_eat;
  assign score_add      = r_score;
  assign expire_pulse   = r_expire;
  assign reject_pulse   = r_reject;

endmodule

// File: tb/tb_reward_slot_manager.sv
// Scoreboard bench for reward_slot_manager: stimulus queues expected events,
// a negedge monitor pops and compares each event the DUT presents.
`timescale 1ns/1ps
module tb_reward_slot_manager;

  localparam int EV_QUERY    = 0;
  localparam int EV_PLACE    = 1;
  localparam int EV_EAT      = 2;
  localparam int EV_EXPIRE   = 3;
  localparam int EV_REJECT   = 4;
  localparam int EV_FIN_RISE = 5;
  localparam int EV_FIN_FALL = 6;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_require;
  logic [1:0] reward_type;
  logic [5:0] random_xpos, random_ypos;
  logic       set_finish, occ_req;
  logic [5:0] occ_xpos, occ_ypos;
  logic       occ_valid, occ_hit, head_valid;
  logic [5:0] head_xpos, head_ypos;
  logic       reward_active, reward_visible;
  logic [5:0] reward_xpos, reward_ypos;
  logic [1:0] reward_kind;
  logic       eat_pulse;
  logic [2:0] score_add;
  logic       expire_pulse, reject_pulse;

  always #5 clk = ~clk;

  reward_slot_manager dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_require    (set_require),
    .reward_type    (reward_type),
    .random_xpos    (random_xpos),
    .random_ypos    (random_ypos),
    .set_finish     (set_finish),
    .occ_req        (occ_req),
    .occ_xpos       (occ_xpos),
    .occ_ypos       (occ_ypos),
    .occ_valid      (occ_valid),
    .occ_hit        (occ_hit),
    .head_valid     (head_valid),
    .head_xpos      (head_xpos),
    .head_ypos      (head_ypos),
    .reward_active  (reward_active),
    .reward_visible (reward_visible),
    .reward_xpos    (reward_xpos),
    .reward_ypos    (reward_ypos),
    .reward_kind    (reward_kind),
    .eat_pulse      (eat_pulse),
    .score_add      (score_add),
    .expire_pulse   (expire_pulse),
    .reject_pulse   (reject_pulse)
  );

  wire [35:0] w_outs = {set_finish, occ_req, occ_xpos, occ_ypos, reward_active, reward_visible,
                        reward_xpos, reward_ypos, reward_kind, eat_pulse, score_add,
                        expire_pulse, reject_pulse};

  task automatic expect_ev(input int k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input int a, input int b, input int c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event t=%0t: got kind=%0d (%0d,%0d,%0d), required no event",
               $time, k, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
        errors++;
        $display("FAIL event_order t=%0t: got kind=%0d (%0d,%0d,%0d), required kind=%0d (%0d,%0d,%0d)",
                 $time, k, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, act, req);
    end
  endtask

  // Monitor: turns DUT output activity into events, fixed order within a cycle
  logic prev_fin = 1'b0;
  logic prev_act = 1'b0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_fin = 1'b0;
      prev_act = 1'b0;
    end else begin
      if (occ_req) got(EV_QUERY, int'(occ_xpos), int'(occ_ypos), 0);
      if (reward_active && !prev_act)
        got(EV_PLACE, int'(reward_xpos), int'(reward_ypos), int'(reward_kind) * 10 + int'(reward_visible));
      if (eat_pulse)    got(EV_EAT, int'(score_add), 0, 0);
      if (expire_pulse) got(EV_EXPIRE, 0, 0, 0);
      if (reject_pulse) got(EV_REJECT, 0, 0, 0);
      if (set_finish && !prev_fin) got(EV_FIN_RISE, 0, 0, 0);
      if (!set_finish && prev_fin) got(EV_FIN_FALL, 0, 0, 0);
      prev_fin = set_finish;
      prev_act = reward_active;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input int t, input int x, input int y);
    set_require = 1'b1;
    reward_type = 2'(t);
    random_xpos = 6'(x);
    random_ypos = 6'(y);
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!occ_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = occ_req;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL occ_req_timeout t=%0t: got no occ_req, required one within 100 cycles", $time);
    end
  endtask

  // Occupancy responder: answer the next query after dly cycles
  task automatic serve(input bit hit, input int dly);
    bit ok;
    wait_req(ok);
    if (ok) begin
      repeat (dly) @(negedge clk);
      occ_valid = 1'b1;
      occ_hit   = hit;
      @(negedge clk);
      occ_valid = 1'b0;
      occ_hit   = 1'b0;
    end
  endtask

  task automatic head(input int x, input int y);
    head_valid = 1'b1;
    head_xpos  = 6'(x);
    head_ypos  = 6'(y);
    @(negedge clk);
    head_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required $finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    bit ok;
    int exp_vis;
    set_require = 1'b0; reward_type = 2'd0; random_xpos = '0; random_ypos = '0;
    occ_valid = 1'b0; occ_hit = 1'b0; head_valid = 1'b0; head_xpos = '0; head_ypos = '0;
    rst_n = 1'b0;
    cyc(2);
    chk("reset_outputs", w_outs, 0);
    rst_n = 1'b1;
    cyc(2);

    // Free cell placement, blink/visibility, miss, then eat with held request
    expect_ev(EV_QUERY, 7, 5, 0);
    expect_ev(EV_PLACE, 7, 5, 21);
    request(2, 7, 5);
    serve(1'b0, 2);
    chk("free_active", reward_active, 1);
    chk("free_pos", {reward_xpos, reward_ypos, reward_kind}, {6'd7, 6'd5, 2'd2});
    for (int i = 0; i < 24; i++) begin
`ifdef REWARD_BLINK_EN
      exp_vis = ((i / 8) % 2 == 0) ? 1 : 0;
`else
      exp_vis = 1;
`endif
      chk("visible", reward_visible, exp_vis);
      @(negedge clk);
    end
    head(8, 5);
    cyc(2);
    chk("no_finish_while_active", set_finish, 0);
    chk("miss_keeps_active", reward_active, 1);
    expect_ev(EV_EAT, 3, 0, 0);
    expect_ev(EV_FIN_RISE, 0, 0, 0);
    head(7, 5);
    cyc(5);
    chk("finish_held", set_finish, 1);
    chk("eaten_inactive", reward_active, 0);
    chk("eaten_invisible", reward_visible, 0);
    expect_ev(EV_FIN_FALL, 0, 0, 0);
    set_require = 1'b0;
    cyc(3);
    chk("finish_dropped", set_finish, 0);

    // Nudge with row and column wrap, then expiry
    expect_ev(EV_QUERY, 19, 9, 0);
    expect_ev(EV_QUERY, 4, 2, 0);
    expect_ev(EV_QUERY, 5, 2, 0);
    expect_ev(EV_PLACE, 5, 2, 11);
    request(1, 19, 9);
    serve(1'b1, 1);
    serve(1'b1, 1);
    serve(1'b0, 1);
    chk("wrap_pos", {reward_xpos, reward_ypos}, {6'd5, 6'd2});
    expect_ev(EV_EXPIRE, 0, 0, 0);
    set_require = 1'b0;
    cyc(3);
    chk("expire_inactive", reward_active, 0);
    chk("expire_no_finish", set_finish, 0);

    // Out-of-range candidate saturates; eat and withdrawal in the same cycle
    expect_ev(EV_QUERY, 19, 2, 0);
    expect_ev(EV_PLACE, 19, 2, 31);
    request(3, 60, 0);
    serve(1'b0, 1);
    expect_ev(EV_EAT, 5, 0, 0);
    expect_ev(EV_FIN_RISE, 0, 0, 0);
    expect_ev(EV_FIN_FALL, 0, 0, 0);
    head_valid = 1'b1; head_xpos = 6'd19; head_ypos = 6'd2;
    set_require = 1'b0;
    @(negedge clk);
    head_valid = 1'b0;
    cyc(4);
    chk("eat_wins_idle", set_finish, 0);

    // Retries exhausted: eight hits then reject
    for (int i = 0; i < 8; i++) expect_ev(EV_QUERY, 10 + i, 3, 0);
    expect_ev(EV_REJECT, 0, 0, 0);
    expect_ev(EV_FIN_RISE, 0, 0, 0);
    request(1, 10, 3);
    for (int i = 0; i < 8; i++) serve(1'b1, 1);
    cyc(3);
    chk("reject_finish", set_finish, 1);
    chk("reject_inactive", reward_active, 0);
    chk("reward_pos_held", {reward_xpos, reward_ypos}, {6'd19, 6'd2});
    expect_ev(EV_FIN_FALL, 0, 0, 0);
    set_require = 1'b0;
    cyc(3);

    // Abort in WAIT_OCC followed by a late response
    expect_ev(EV_QUERY, 8, 8, 0);
    request(2, 8, 8);
    wait_req(ok);
    @(negedge clk);
    set_require = 1'b0;
    cyc(2);
    occ_valid = 1'b1; occ_hit = 1'b0;
    @(negedge clk);
    occ_valid = 1'b0;
    cyc(3);
    chk("late_occ_inactive", reward_active, 0);
    chk("late_occ_no_finish", set_finish, 0);

    // Abort in SETTLE, then a type-0 request that must be ignored
    request(2, 6, 6);
    cyc(2);
    set_require = 1'b0;
    cyc(8);
    request(0, 6, 6);
    cyc(12);
    chk("type0_ignored", occ_req, 0);
    set_require = 1'b0;
    cyc(2);

    // Asynchronous reset while FINISH holds set_finish
    expect_ev(EV_QUERY, 12, 6, 0);
    expect_ev(EV_PLACE, 12, 6, 11);
    request(1, 12, 6);
    serve(1'b0, 1);
    expect_ev(EV_EAT, 1, 0, 0);
    expect_ev(EV_FIN_RISE, 0, 0, 0);
    head(12, 6);
    cyc(3);
    chk("pre_reset_finish", set_finish, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", w_outs, 0);
    @(negedge clk);
    set_require = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("post_reset_outputs", w_outs, 0);

    cyc(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
